n4_b10_stopwatch_ctrl: RTL and testbench

- Sequencing controller for a 4-digit BCD up counter (4x 4-bit digits, carry-out eu, enable ei, active-low reset_).
- Turns start/stop/clear/lap commands into a prescaled count enable and a counter clear, captures lap values, and detects target match and overflow.
- Sits between the user-command logic and the counter; the counter's digits and eu feed back into this block.

---
 rtl/n4_b10_stopwatch_ctrl_if.sv | 28 ++
 rtl/n4_b10_stopwatch_ctrl.sv | 136 +++++++++++++
 tb/tb_n4_b10_stopwatch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/n4_b10_stopwatch_ctrl_if.sv
// Command/status bundle between user-command logic, the stopwatch controller
// and the 4-digit BCD counter it sequences.
interface n4_b10_stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        lap;
  logic [15:0] q;
  logic        eu;
  logic [15:0] target;
  logic        cnt_ei;
  logic        cnt_reset_;
  logic [15:0] lap_q;
  logic        lap_valid;
  logic        alarm;
  logic        ovf;
  logic [1:0]  state;

  modport master (
    output start, stop, clear, lap, q, eu, target,
    input  cnt_ei, cnt_reset_, lap_q, lap_valid, alarm, ovf, state
  );

  modport slave (
    input  start, stop, clear, lap, q, eu, target,
    output cnt_ei, cnt_reset_, lap_q, lap_valid, alarm, ovf, state
  );
endinterface

// File: rtl/n4_b10_stopwatch_ctrl.sv
// Stopwatch sequencer: prescaled count enable, counter clear, lap capture, target/overflow detect.
// Optional macro STOPWATCH_AUTO_RELOAD_EN: a target match restarts counting instead of entering DONE.
module n4_b10_stopwatch_ctrl #(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned PW       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  n4_b10_stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [PW-1:0] LP_TERM = PW'(PRESCALE - 32'd1);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_cnt_ei;
  logic          r_cnt_rst_n;
  logic [15:0]   r_lap_q;
  logic          r_lap_valid;
  logic          r_alarm;
  logic          r_ovf;

  logic w_ovf_hit;
  logic w_match;
  logic w_lap_ok;
  logic w_halt;
  logic w_reload;

  // The counter wraps on the same edge that sees our enable together with its carry-out.
  assign w_ovf_hit = r_cnt_ei & bus.eu;
  assign w_lap_ok  = bus.lap & ((r_state == ST_RUN) | (r_state == ST_PAUSE));

`ifdef STOPWATCH_AUTO_RELOAD_EN
  // While the counter clear is in flight q still shows the old target; do not re-trigger.
  assign w_match  = (r_state == ST_RUN) & (bus.target != 16'h0000) & (bus.q == bus.target) & r_cnt_rst_n;
  assign w_halt   = w_ovf_hit;
  assign w_reload = w_match & ~w_ovf_hit;
`else
  assign w_match  = (r_state == ST_RUN) & (bus.target != 16'h0000) & (bus.q == bus.target);
  assign w_halt   = w_ovf_hit | w_match;
  assign w_reload = 1'b0;
`endif

  // Command sequencing, prescaler and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_cnt_ei    <= 1'b0;
      r_cnt_rst_n <= 1'b0;
      r_lap_q     <= 16'h0000;
      r_lap_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt_ei    <= 1'b0;
      r_lap_valid <= 1'b0;
      r_cnt_rst_n <= 1'b1;
`ifdef STOPWATCH_AUTO_RELOAD_EN
      r_alarm     <= 1'b0;
`endif
      if (bus.clear) begin
        r_state     <= ST_IDLE;
        r_presc     <= '0;
        r_cnt_rst_n <= 1'b0;
        r_lap_q     <= 16'h0000;
        r_alarm     <= 1'b0;
        r_ovf       <= 1'b0;
      end else begin
        if (w_lap_ok) begin
          r_lap_q     <= bus.q;
          r_lap_valid <= 1'b1;
        end
        if (w_ovf_hit) begin
          r_ovf <= 1'b1;
        end
        if (w_match) begin
          r_alarm <= 1'b1;
        end
        if (w_halt) begin
          r_state <= ST_DONE;
        end else if (w_reload) begin
          r_cnt_rst_n <= 1'b0;
          r_presc     <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (bus.start) begin
                r_state <= ST_RUN;
                r_presc <= '0;
              end
            end
            ST_RUN: begin
              // Stop freezes the prescaler so a later resume keeps the exact phase.
              if (bus.stop) begin
                r_state <= ST_PAUSE;
              end else if (r_presc == LP_TERM) begin
                r_presc  <= '0;
                r_cnt_ei <= 1'b1;
              end else begin
                r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
              end
            end
            ST_PAUSE: begin
              if (bus.start) begin
                r_state <= ST_RUN;
              end
            end
            ST_DONE: begin
              r_state <= ST_DONE;
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.cnt_ei     = r_cnt_ei;
  assign bus.cnt_reset_ = r_cnt_rst_n;
  assign bus.lap_q      = r_lap_q;
  assign bus.lap_valid  = r_lap_valid;
  assign bus.alarm      = r_alarm;
  assign bus.ovf        = r_ovf;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_n4_b10_stopwatch_ctrl.sv
// Scoreboard bench: a BCD counter environment closes the loop, a run-tick reference
// model queues expected outputs every edge, and a monitor pops and compares them.
module tb_n4_b10_stopwatch_ctrl;
  localparam int P = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  n4_b10_stopwatch_ctrl_if bus ();

  n4_b10_stopwatch_ctrl #(.PRESCALE(P), .PW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  // ---------------- counter environment ----------------
  logic [15:0] env_q   = 16'h0000;
  logic        pre_en  = 1'b0;
  logic [15:0] pre_val = 16'h0000;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (pre_en) env_q <= pre_val;
    else if (!bus.cnt_reset_) env_q <= 16'h0000;
    else if (bus.cnt_ei) env_q <= bcd_inc(env_q);
  end
  assign bus.q  = env_q;
  assign bus.eu = (env_q == 16'h9999);

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [1:0]  st;
    logic        ei;
    logic        rn;
    logic [15:0] lq;
    logic        lv;
    logic        al;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];

  // Mode codes: 0 idle, 1 run, 2 pause, 3 done. Ticks = run cycles elapsed since start.
  initial begin
    int          mode;
    int          ticks;
    logic        ei_prev, rn_prev, ovf_hit, match, e_ei, e_rn, e_lv, al, ov;
    logic [15:0] lq;
    exp_t        e;
    mode = 0; ticks = 0; ei_prev = 1'b0; rn_prev = 1'b0;
    al = 1'b0; ov = 1'b0; lq = 16'h0000;
    forever begin
      @(posedge clock);
      cyc++;
      e_ei = 1'b0; e_lv = 1'b0; e_rn = 1'b1;
      if (reset) begin
        mode = 0; ticks = 0; al = 1'b0; ov = 1'b0; lq = 16'h0000; e_rn = 1'b0;
      end else if (bus.clear) begin
        mode = 0; ticks = 0; al = 1'b0; ov = 1'b0; lq = 16'h0000; e_rn = 1'b0;
      end else begin
        ovf_hit = ei_prev && bus.eu;
        match   = (mode == 1) && (bus.target != 16'h0000) && (bus.q == bus.target);
`ifdef STOPWATCH_AUTO_RELOAD_EN
        match = match && rn_prev;
        al = 1'b0;
`endif
        if (bus.lap && (mode == 1 || mode == 2)) begin
          lq = bus.q; e_lv = 1'b1;
        end
        if (ovf_hit) ov = 1'b1;
        if (match) al = 1'b1;
`ifdef STOPWATCH_AUTO_RELOAD_EN
        if (ovf_hit) mode = 3;
        else if (match) begin e_rn = 1'b0; ticks = 0; end
`else
        if (ovf_hit || match) mode = 3;
`endif
        else begin
          case (mode)
            0: if (bus.start) begin mode = 1; ticks = 0; end
            1: if (bus.stop) mode = 2;
               else begin
                 ticks++;
                 if (ticks % P == 0) e_ei = 1'b1;
               end
            2: if (bus.start) mode = 1;
            default: ;
          endcase
        end
      end
      ei_prev = e_ei;
      rn_prev = e_rn;
      e.st = 2'(mode); e.ei = e_ei; e.rn = e_rn; e.lq = lq;
      e.lv = e_lv; e.al = al; e.ov = ov;
      sb_q.push_back(e);
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end else n_pass++;
  endtask

  // Monitor: one registered-output snapshot per edge, compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty cyc=%0d got=0 exp=1", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("state",      16'(bus.state),      16'(e.st));
        chk("cnt_ei",     16'(bus.cnt_ei),     16'(e.ei));
        chk("cnt_reset_", 16'(bus.cnt_reset_), 16'(e.rn));
        chk("lap_q",      bus.lap_q,           e.lq);
        chk("lap_valid",  16'(bus.lap_valid),  16'(e.lv));
        chk("alarm",      16'(bus.alarm),      16'(e.al));
        chk("ovf",        16'(bus.ovf),        16'(e.ov));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic p, input logic c, input logic l);
    bus.start = s; bus.stop = p; bus.clear = c; bus.lap = l;
    @(negedge clock);
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_q(input logic [15:0] v, input int budget);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      if (env_q == v) hit = 1'b1;
      else @(negedge clock);
    end
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_q timeout got=%h exp=%h", env_q, v);
    end
  endtask

  initial begin
    logic [15:0] tgts [4];
    tgts[0] = 16'h0000; tgts[1] = 16'h0003; tgts[2] = 16'h0007; tgts[3] = 16'h0012;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0;
    bus.target = 16'h0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(2);

    // basic counting: enables every P cycles
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(14);
    step(1'b0, 1'b0, 1'b1, 1'b0); idle(3);

    // pause/resume phase retention
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0); idle(10);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(8);
    step(1'b0, 1'b0, 1'b1, 1'b0); idle(3);

    // overflow 9999 -> 0000, DONE ignores start, clear recovers
    pre_val = 16'h9999; pre_en = 1'b1; @(negedge clock); pre_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(P + 3);
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0); idle(3);

    // target match
    bus.target = 16'h0005;
    step(1'b1, 1'b0, 1'b0, 1'b0); idle(5 * P + 6);
    step(1'b0, 1'b0, 1'b1, 1'b0); bus.target = 16'h0000; idle(3);

    // lap in RUN and PAUSE, then lap together with clear
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_q(16'h0003, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_q(16'h0007, 100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1); idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1); idle(3);

    // asynchronous reset mid-RUN with prescaler at 2
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b1; #1;
    chk("async_state",  16'(bus.state),      16'h0000);
    chk("async_ei",     16'(bus.cnt_ei),     16'h0000);
    chk("async_rst_n",  16'(bus.cnt_reset_), 16'h0000);
    chk("async_lapq",   bus.lap_q,           16'h0000);
    chk("async_alarm",  16'(bus.alarm),      16'h0000);
    chk("async_ovf",    16'(bus.ovf),        16'h0000);
    idle(2); reset = 1'b0; idle(4);

    // randomized commands, targets and near-overflow preloads
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 99) < 10);
      bus.stop  = ($urandom_range(0, 99) < 5);
      bus.clear = ($urandom_range(0, 99) < 3);
      bus.lap   = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 149) == 0) bus.target = tgts[$urandom_range(0, 3)];
      pre_val = 16'h9998;
      pre_en  = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.lap = 1'b0; pre_en = 1'b0;
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
